// File: rtl/x9_pkg.sv
// Shared X9 types and default widths for the data-memory arbiter.
package x9_pkg;

    localparam int unsigned X9_AW = 8;
    localparam int unsigned X9_DW = 8;

    // Which requester owns the read response due next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } arb_owner_t;

    // RUN: core has priority; LOCK: host owns memory exclusively.
    typedef enum logic {
        ARB_RUN  = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's command/grant/response channel into the data-memory arbiter.
interface dmem_arbiter_if
    import x9_pkg::*;
#(
    parameter int unsigned AW = X9_AW,
    parameter int unsigned DW = X9_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    // Requester side: issues commands, receives grant and read data.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_starve.sv
// Saturating count of contested cycles the host has lost; flags when the host must win.
module dmem_arb_starve #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic host_req,
    input  logic host_gnt,
    output logic force_host
);
    localparam int unsigned CW = 4;

    logic [CW-1:0] cnt;

    // Count host losses while in RUN; frozen while locked, cleared once the host is served or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (run) begin
            if (host_gnt || !host_req) begin
                cnt <= '0;
            end else if (cnt != CW'(STARVE_MAX)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign force_host = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the host loader port.
module dmem_arbiter
    import x9_pkg::*;
#(
    parameter int unsigned AW         = X9_AW,
    parameter int unsigned DW         = X9_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  cpu,
    dmem_arbiter_if.slave  host,
    input  logic           host_lock,
    output logic           locked,
    output logic           mem_en,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);
    arb_state_t state;
    arb_owner_t rd_owner;
    logic       cpu_gnt_c;
    logic       host_gnt_c;
    logic       force_host;

    // Lock state follows host_lock one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_RUN;
        end else begin
            state <= host_lock ? ARB_LOCK : ARB_RUN;
        end
    end

    assign locked = (state == ARB_LOCK);

    dmem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .run        (state == ARB_RUN),
        .host_req   (host.req),
        .host_gnt   (host_gnt_c),
        .force_host (force_host)
    );

    // Zero-latency grant; nothing is granted while reset is held.
    always_comb begin
        cpu_gnt_c  = 1'b0;
        host_gnt_c = 1'b0;
        if (reset) begin
            if (state == ARB_LOCK) begin
                host_gnt_c = host.req;
            end else if (cpu.req && host.req) begin
                host_gnt_c = force_host;
                cpu_gnt_c  = !force_host;
            end else begin
                cpu_gnt_c  = cpu.req;
                host_gnt_c = host.req;
            end
        end
    end

    assign cpu.gnt  = cpu_gnt_c;
    assign host.gnt = host_gnt_c;

    // Memory command is the granted requester's command, all zero when idle.
    always_comb begin
        mem_en    = cpu_gnt_c | host_gnt_c;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt_c) begin
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (host_gnt_c) begin
            mem_we    = host.we;
            mem_addr  = host.addr;
            mem_wdata = host.wdata;
        end
    end

    // Remember who issued the read so next cycle's data goes back to them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= OWN_NONE;
        end else if (cpu_gnt_c && !cpu.we) begin
            rd_owner <= OWN_CPU;
        end else if (host_gnt_c && !host.we) begin
            rd_owner <= OWN_HOST;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign cpu.rvalid  = (rd_owner == OWN_CPU);
    assign host.rvalid = (rd_owner == OWN_HOST);
    assign cpu.rdata   = (rd_owner == OWN_CPU)  ? mem_rdata : '0;
    assign host.rdata  = (rd_owner == OWN_HOST) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a rule-level model.
module tb_dmem_arbiter;
    import x9_pkg::*;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_lock;
    logic          locked;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) host_if ();

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_if.slave),
        .host      (host_if.slave),
        .host_lock (host_lock),
        .locked    (locked),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous single-port RAM.
    logic [DW-1:0] ram [256] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int ref_mem [256];
    bit m_lock;
    int m_starve;
    int m_pend;       // 0 none, 1 cpu, 2 host
    int m_pend_data;

    // Last expected grants and observed outputs of the most recent tick.
    bit last_cg, last_hg;
    logic obs_cg, obs_hg, obs_crv, obs_hrv, obs_locked;
    logic [DW-1:0] obs_crd, obs_hrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: starts and ends at a falling edge, checks before the rising edge.
    task automatic tick();
        bit ec, eh, ewe, erv_c, erv_h;
        int ea, ed;
        #3;
        ec = 0; eh = 0;
        if (reset) begin
            if (m_lock) begin
                eh = host_if.req;
            end else if (cpu_if.req && host_if.req) begin
                if (m_starve == SMAX) eh = 1; else ec = 1;
            end else begin
                ec = cpu_if.req;
                eh = host_if.req;
            end
        end
        ewe = 0; ea = 0; ed = 0;
        if (ec) begin ewe = cpu_if.we; ea = cpu_if.addr; ed = cpu_if.wdata; end
        else if (eh) begin ewe = host_if.we; ea = host_if.addr; ed = host_if.wdata; end
        erv_c = reset && (m_pend == 1);
        erv_h = reset && (m_pend == 2);

        obs_cg = cpu_if.gnt;    obs_hg = host_if.gnt;
        obs_crv = cpu_if.rvalid; obs_hrv = host_if.rvalid;
        obs_crd = cpu_if.rdata;  obs_hrd = host_if.rdata;
        obs_locked = locked;

        chk("cpu_gnt",     32'(cpu_if.gnt),    32'(ec));
        chk("host_gnt",    32'(host_if.gnt),   32'(eh));
        chk("mem_en",      32'(mem_en),        32'(ec | eh));
        chk("mem_we",      32'(mem_we),        32'(ewe));
        chk("mem_addr",    32'(mem_addr),      32'(ea));
        chk("mem_wdata",   32'(mem_wdata),     32'(ed));
        chk("cpu_rvalid",  32'(cpu_if.rvalid), 32'(erv_c));
        chk("host_rvalid", 32'(host_if.rvalid),32'(erv_h));
        chk("cpu_rdata",   32'(cpu_if.rdata),  erv_c ? 32'(m_pend_data) : 32'd0);
        chk("host_rdata",  32'(host_if.rdata), erv_h ? 32'(m_pend_data) : 32'd0);
        chk("locked",      32'(locked),        32'(reset && m_lock));
        last_cg = ec; last_hg = eh;

        @(posedge clk);
        if (!reset) begin
            m_lock = 0; m_starve = 0; m_pend = 0;
        end else begin
            m_pend = 0;
            if (ec) begin
                if (cpu_if.we) ref_mem[cpu_if.addr] = int'(cpu_if.wdata);
                else begin m_pend = 1; m_pend_data = ref_mem[cpu_if.addr]; end
            end
            if (eh) begin
                if (host_if.we) ref_mem[host_if.addr] = int'(host_if.wdata);
                else begin m_pend = 2; m_pend_data = ref_mem[host_if.addr]; end
            end
            if (!m_lock) begin
                if (eh || !host_if.req) m_starve = 0;
                else if (m_starve < SMAX) m_starve++;
            end
            m_lock = host_lock;
        end
        @(negedge clk);
    endtask

    task automatic set_cpu(input bit req, input bit we, input int addr, input int data);
        cpu_if.req = req; cpu_if.we = we; cpu_if.addr = AW'(addr); cpu_if.wdata = DW'(data);
    endtask

    task automatic set_host(input bit req, input bit we, input int addr, input int data);
        host_if.req = req; host_if.we = we; host_if.addr = AW'(addr); host_if.wdata = DW'(data);
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 0;
        m_lock = 0; m_starve = 0; m_pend = 0; m_pend_data = 0;
        reset = 1'b0; host_lock = 1'b0;
        set_cpu(1, 0, 5, 0);
        set_host(1, 0, 4, 0);
        @(negedge clk);

        // Reset held with both requesting: everything quiet.
        tick();
        tick();
        chk("rst_cpu_gnt",  32'(obs_cg),  32'd0);
        chk("rst_host_gnt", 32'(obs_hg),  32'd0);
        chk("rst_rdata",    32'(obs_crd | obs_hrd), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_cpu_first", 32'(obs_cg), 32'd1);
        set_cpu(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        tick();

        // Host-only write then read of addr 0.
        set_host(1, 1, 0, 8'hF0);
        tick();
        chk("host_wr_gnt", 32'(obs_hg), 32'd1);
        set_host(1, 0, 0, 0);
        tick();
        chk("host_rd_gnt", 32'(obs_hg), 32'd1);
        set_host(0, 0, 0, 0);
        tick();
        chk("host_rvalid_f0", 32'(obs_hrv), 32'd1);
        chk("host_rdata_f0",  32'(obs_hrd), 32'hF0);
        chk("cpu_rvalid_idle", 32'(obs_crv), 32'd0);

        // Continuous contention: CPU x4 then HOST, repeating.
        set_cpu(1, 0, 2, 0);
        set_host(1, 0, 4, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("contend_host_%0d", i), 32'(obs_hg), (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("contend_cpu_%0d", i),  32'(obs_cg), (i % 5 == 4) ? 32'd0 : 32'd1);
        end
        set_cpu(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        tick();

        // Same-cycle conflict on addr 3: core write wins, host read sees new data.
        set_cpu(1, 1, 3, 8'hAA);
        set_host(1, 0, 3, 0);
        tick();
        chk("conflict_cpu_first", 32'(obs_cg), 32'd1);
        set_cpu(0, 0, 0, 0);
        tick();
        chk("conflict_host_next", 32'(obs_hg), 32'd1);
        set_host(0, 0, 0, 0);
        tick();
        chk("conflict_rdata", 32'(obs_hrd), 32'hAA);

        // Preload addrs 1, 6, 7 through the host port.
        set_host(1, 1, 1, 8'h01); tick();
        set_host(1, 1, 6, 8'hAA); tick();
        set_host(1, 1, 7, 8'h55); tick();
        set_host(0, 0, 0, 0);     tick();

        // Lock rises in the cycle a core read is granted.
        set_cpu(1, 0, 1, 0);
        host_lock = 1'b1;
        tick();
        chk("lock_cpu_read_gnt", 32'(obs_cg), 32'd1);
        set_cpu(1, 0, 2, 0);
        set_host(1, 0, 6, 0);
        tick();
        chk("lock_cpu_rvalid", 32'(obs_crv), 32'd1);
        chk("lock_cpu_rdata",  32'(obs_crd), 32'h01);
        chk("lock_locked",     32'(obs_locked), 32'd1);
        chk("lock_cpu_stall0", 32'(obs_cg), 32'd0);
        set_host(1, 0, 7, 0);
        tick();
        chk("lock_rd6", 32'(obs_hrd), 32'hAA);
        chk("lock_cpu_stall1", 32'(obs_cg), 32'd0);
        set_host(0, 0, 0, 0);
        tick();
        chk("lock_rd7", 32'(obs_hrd), 32'h55);
        chk("lock_cpu_stall2", 32'(obs_cg), 32'd0);
        host_lock = 1'b0;
        tick();
        chk("unlock_still_locked", 32'(obs_locked), 32'd1);
        chk("unlock_cpu_stall", 32'(obs_cg), 32'd0);
        tick();
        chk("unlock_cpu_gnt", 32'(obs_cg), 32'd1);
        chk("unlock_locked", 32'(obs_locked), 32'd0);
        set_cpu(0, 0, 0, 0);
        tick();

        // Reset right after a host read grant drops the response.
        set_host(1, 0, 0, 0);
        tick();
        chk("rstrd_gnt", 32'(obs_hg), 32'd1);
        set_host(0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("rstrd_no_rvalid", 32'(obs_hrv), 32'd0);
        reset = 1'b1;
        tick();
        chk("rstrd_after_rel", 32'(obs_hrv | obs_crv), 32'd0);

        // Randomized traffic; commands are held until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(cpu_if.req && !last_cg))
                set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 7), $urandom_range(0, 255));
            if (!(host_if.req && !last_hg))
                set_host($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 7), $urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) host_lock = ~host_lock;
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
